// File: rtl/missile_fire_scheduler_if.sv
// Signal bundle between the fire scheduler, input decode and the per-slot missile movers.
// launch is a one-cycle strobe to one slot; that slot acknowledges by raising slot_busy no earlier than the next cycle.
interface missile_fire_scheduler_if #(
  parameter int NSLOT = 3
);
  logic             pause;
  logic             shoot_req;
  logic             burst_req;
  logic [NSLOT-1:0] slot_busy;
  logic [NSLOT-1:0] launch;
  logic [3:0]       ammo;
  logic             reloading;
  logic             last_src;
  logic [2:0]       burst_left;
  logic [1:0]       state_dbg;

  modport master (
    input  pause, shoot_req, burst_req, slot_busy,
    output launch, ammo, reloading, last_src, burst_left, state_dbg
  );

  modport slave (
    output pause, shoot_req, burst_req, slot_busy,
    input  launch, ammo, reloading, last_src, burst_left, state_dbg
  );
endinterface

// File: rtl/missile_fire_scheduler.sv
// Arbitrates manual and burst fire requests onto the lowest free missile slot,
// owning the magazine, the inter-shot gap and the empty-magazine reload.
module missile_fire_scheduler #(
  parameter int NSLOT        = 3,
  parameter int AMMO_MAX     = 6,
  parameter int RELOAD_TICKS = 20,
  parameter int GAP_TICKS    = 4,
  parameter int BURST_LEN    = 3
) (
  input  logic                     clk_22,
  input  logic                     rst,
  missile_fire_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GAP    = 2'd1,
    S_RELOAD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [3:0]       ammo_q, ammo_d;
  logic             manual_pend_q, manual_pend_d;
  logic [2:0]       burst_left_q, burst_left_d;
  logic             last_src_q, last_src_d;
  logic [NSLOT-1:0] launch_q, launch_d;
  logic             shoot_q, burst_q;

  logic             shoot_rise, burst_rise;
  logic [NSLOT-1:0] pick;
  logic             pick_found;
  logic             grant_burst;
  logic             can_launch;

  always_ff @(posedge clk_22 or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ammo_q        <= 4'(AMMO_MAX);
      manual_pend_q <= 1'b0;
      burst_left_q  <= '0;
      last_src_q    <= 1'b1;
      launch_q      <= '0;
      shoot_q       <= 1'b0;
      burst_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ammo_q        <= ammo_d;
      manual_pend_q <= manual_pend_d;
      burst_left_q  <= burst_left_d;
      last_src_q    <= last_src_d;
      launch_q      <= launch_d;
      shoot_q       <= bus.shoot_req;
      burst_q       <= bus.burst_req;
    end
  end

  // Lowest-index free slot, one-hot.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (!bus.slot_busy[i] && !pick_found) begin
        pick[i]    = 1'b1;
        pick_found = 1'b1;
      end
    end
  end

  assign shoot_rise = bus.shoot_req & ~shoot_q & ~bus.pause;
  assign burst_rise = bus.burst_req & ~burst_q & ~bus.pause;

  // With both sources pending, the source not granted last time wins.
  assign grant_burst = (burst_left_q != 3'd0) && (!manual_pend_q || !last_src_q);
  assign can_launch  = (state_q == S_IDLE) && !bus.pause && (ammo_q != 4'd0) &&
                       (manual_pend_q || (burst_left_q != 3'd0)) && pick_found;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ammo_d        = ammo_q;
    manual_pend_d = manual_pend_q;
    burst_left_d  = burst_left_q;
    last_src_d    = last_src_q;
    launch_d      = '0;

    if (!bus.pause) begin
      case (state_q)
        S_IDLE: begin
          if (can_launch) begin
            launch_d   = pick;
            ammo_d     = ammo_q - 4'd1;
            last_src_d = grant_burst;
            if (grant_burst) burst_left_d  = burst_left_q - 3'd1;
            else             manual_pend_d = 1'b0;
            cnt_d   = '0;
            state_d = (ammo_q == 4'd1) ? S_RELOAD : S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_q == 5'(GAP_TICKS - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_RELOAD: begin
          if (cnt_q == 5'(RELOAD_TICKS - 1)) begin
            ammo_d  = 4'(AMMO_MAX);
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase

      // A fresh edge in the grant cycle re-arms manual_pend after the grant clears it.
      if (state_d == S_RELOAD) begin
        manual_pend_d = 1'b0;
        burst_left_d  = '0;
      end else if (state_q != S_RELOAD) begin
        if (shoot_rise) manual_pend_d = 1'b1;
        if (burst_rise && (burst_left_q == 3'd0)) burst_left_d = 3'(BURST_LEN);
      end
    end
  end

  assign bus.launch     = launch_q;
  assign bus.ammo       = ammo_q;
  assign bus.reloading  = (state_q == S_RELOAD);
  assign bus.last_src   = last_src_q;
  assign bus.burst_left = burst_left_q;
  assign bus.state_dbg  = state_q;

endmodule
